// File: rtl/directory_msg_queue.sv
// Per-destination message FIFO between the directory request generator and one consumer.
// Holds {operation, addr, data, source} entries and reports occupancy, full and sticky overflow.
module directory_msg_queue #(
    parameter int CL_SIZE = 128,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc,
    input  logic [2:0]                 operation,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [CL_SIZE-1:0]         data,
    input  logic [1:0]                 source,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_operation,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [CL_SIZE-1:0]         out_data,
    output logic [1:0]                 out_source,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [2:0]         op_mem   [DEPTH];
    logic [ADDR_W-1:0]  addr_mem [DEPTH];
    logic [CL_SIZE-1:0] data_mem [DEPTH];
    logic [1:0]         src_mem  [DEPTH];

    logic [PTR_W-1:0] rptr, wptr;
    logic             real_msg, push, pop, drop;

    assign real_msg = alloc && (operation != 3'd0);
    assign pop      = out_valid && out_ready;
    assign push     = real_msg && ((count < DEPTH_C) || pop);
    assign drop     = real_msg && !push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage is data-only and deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wptr]   <= operation;
            addr_mem[wptr] <= addr;
            data_mem[wptr] <= data;
            src_mem[wptr]  <= source;
        end
    end

    assign out_valid     = (count != '0);
    assign full          = (count == DEPTH_C);
    assign out_operation = out_valid ? op_mem[rptr]   : '0;
    assign out_addr      = out_valid ? addr_mem[rptr] : '0;
    assign out_data      = out_valid ? data_mem[rptr] : '0;
    assign out_source    = out_valid ? src_mem[rptr]  : '0;

endmodule

// File: tb/tb_directory_msg_queue.sv
// Directed bench for directory_msg_queue: vector table plus wrap-around and async-reset sequences.
module tb_directory_msg_queue;

    localparam int CL_SIZE = 128;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               alloc = 1'b0;
    logic [2:0]         operation = '0;
    logic [ADDR_W-1:0]  addr = '0;
    logic [CL_SIZE-1:0] data = '0;
    logic [1:0]         source = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [2:0]         out_operation;
    logic [ADDR_W-1:0]  out_addr;
    logic [CL_SIZE-1:0] out_data;
    logic [1:0]         out_source;
    logic               full;
    logic [2:0]         count;
    logic               overflow;

    directory_msg_queue #(.CL_SIZE(CL_SIZE), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .alloc(alloc), .operation(operation), .addr(addr),
        .data(data), .source(source), .out_valid(out_valid), .out_ready(out_ready),
        .out_operation(out_operation), .out_addr(out_addr), .out_data(out_data),
        .out_source(out_source), .full(full), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               rst_n;
        logic               alloc;
        logic [2:0]         op;
        logic [ADDR_W-1:0]  addr;
        logic [CL_SIZE-1:0] data;
        logic [1:0]         src;
        logic               ready;
        logic               e_valid;
        logic [2:0]         e_op;
        logic [ADDR_W-1:0]  e_addr;
        logic [CL_SIZE-1:0] e_data;
        logic [1:0]         e_src;
        logic [2:0]         e_count;
        logic               e_full;
        logic               e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic r, input logic a, input logic [2:0] op,
                                input logic [31:0] ad, input logic [127:0] d, input logic [1:0] s,
                                input logic rdy, input logic ev, input logic [2:0] eop,
                                input logic [31:0] ead, input logic [127:0] ed, input logic [1:0] es,
                                input logic [2:0] ec, input logic ef, input logic eo);
        vec_t v;
        v.rst_n = r; v.alloc = a; v.op = op; v.addr = ad; v.data = d; v.src = s; v.ready = rdy;
        v.e_valid = ev; v.e_op = eop; v.e_addr = ead; v.e_data = ed; v.e_src = es;
        v.e_count = ec; v.e_full = ef; v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc = 1'b0; operation = '0; addr = '0; data = '0; source = '0; out_ready = 1'b0;
    endtask

    task automatic push_one(input logic [2:0] op, input logic [31:0] ad, input logic [1:0] s);
        alloc = 1'b1; operation = op; addr = ad; data = 128'(ad); source = s; out_ready = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        // reset then idle
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 128'(out_valid), 128'd0);
        chk("reset count",     128'(count),     128'd0);
        chk("reset full",      128'(full),      128'd0);
        chk("reset overflow",  128'(overflow),  128'd0);
        chk("reset out_addr",  128'(out_addr),  128'd0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1,1,0,'h1234,'h99,1,0, 0,0,0,0,0, 0,0,0));
        vecs.push_back(mk(1,1,3,'h40,'h5,2,0,   1,3,'h40,'h5,2, 1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,        1,3,'h40,'h5,2, 1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,1,        0,0,0,0,0, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,1,        0,0,0,0,0, 0,0,0));
        vecs.push_back(mk(1,1,4,'h0,'h11,3,0,   1,4,'h0,'h11,3, 1,0,0));
        vecs.push_back(mk(1,1,4,'h40,'h22,3,0,  1,4,'h0,'h11,3, 2,0,0));
        vecs.push_back(mk(1,1,4,'h80,'h33,3,0,  1,4,'h0,'h11,3, 3,0,0));
        vecs.push_back(mk(1,1,4,'hC0,'h44,3,0,  1,4,'h0,'h11,3, 4,1,0));
        vecs.push_back(mk(1,1,4,'h100,'h55,3,0, 1,4,'h0,'h11,3, 4,1,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,        1,4,'h0,'h11,3, 4,1,1));
        vecs.push_back(mk(1,0,0,0,0,0,1,        1,4,'h40,'h22,3, 3,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,1,        1,4,'h80,'h33,3, 2,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,1,        1,4,'hC0,'h44,3, 1,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,1,        0,0,0,0,0, 0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,        0,0,0,0,0, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,        0,0,0,0,0, 0,0,0));
        vecs.push_back(mk(1,1,5,'h1000,'h61,1,0, 1,5,'h1000,'h61,1, 1,0,0));
        vecs.push_back(mk(1,1,4,'h1040,'h62,2,0, 1,5,'h1000,'h61,1, 2,0,0));
        vecs.push_back(mk(1,1,6,'h1080,'h63,3,0, 1,5,'h1000,'h61,1, 3,0,0));
        vecs.push_back(mk(1,1,7,'h10C0,'h64,1,0, 1,5,'h1000,'h61,1, 4,1,0));
        vecs.push_back(mk(1,1,5,'h200,'h65,2,1,  1,4,'h1040,'h62,2, 4,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,1,         1,6,'h1080,'h63,3, 3,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,1,         1,7,'h10C0,'h64,1, 2,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,1,         1,5,'h200,'h65,2, 1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,1,         0,0,0,0,0, 0,0,0));
        vecs.push_back(mk(1,1,2,'h300,'h70,3,1,  1,2,'h300,'h70,3, 1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,1,         0,0,0,0,0, 0,0,0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst_n; alloc = vecs[i].alloc; operation = vecs[i].op;
            addr = vecs[i].addr; data = vecs[i].data; source = vecs[i].src;
            out_ready = vecs[i].ready;
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(vecs[i].e_valid));
            chk($sformatf("v%0d out_operation", i), 128'(out_operation), 128'(vecs[i].e_op));
            chk($sformatf("v%0d out_addr", i), 128'(out_addr), 128'(vecs[i].e_addr));
            chk($sformatf("v%0d out_source", i), 128'(out_source), 128'(vecs[i].e_src));
            chk($sformatf("v%0d count", i), 128'(count), 128'(vecs[i].e_count));
            chk($sformatf("v%0d full", i), 128'(full), 128'(vecs[i].e_full));
            chk($sformatf("v%0d overflow", i), 128'(overflow), 128'(vecs[i].e_ovf));
            if (vecs[i].e_valid && (vecs[i].e_op inside {3'd2, 3'd4, 3'd7}))
                chk($sformatf("v%0d out_data", i), out_data, vecs[i].e_data);
        end
        idle_inputs();
        rst = 1'b1;

        // wrap-around stress: generator stalls on full, consumer ready toggles 1010...
        begin
            int sent = 0, rcvd = 0, cyc = 0, max_cnt = 0;
            logic did_pop, did_push;
            logic [CL_SIZE-1:0] head_d;
            logic [ADDR_W-1:0]  head_a;
            while (rcvd < 20 && cyc < 200) begin
                did_push  = (sent < 20) && !full;
                alloc     = did_push;
                operation = 3'd4;
                addr      = ADDR_W'(sent * 64);
                data      = CL_SIZE'(sent);
                source    = 2'd3;
                out_ready = (cyc % 2 == 0);
                #1;
                did_pop = out_valid && out_ready;
                head_d  = out_data;
                head_a  = out_addr;
                @(posedge clk); #1;
                if (did_pop) begin
                    chk($sformatf("wrap data %0d", rcvd), head_d, CL_SIZE'(rcvd));
                    chk($sformatf("wrap addr %0d", rcvd), 128'(head_a), 128'(rcvd * 64));
                    rcvd++;
                end
                if (did_push) sent++;
                if (int'(count) > max_cnt) max_cnt = int'(count);
                cyc++;
            end
            idle_inputs();
            chk("wrap received", 128'(rcvd), 128'd20);
            chk("wrap count bounded", 128'(max_cnt <= DEPTH), 128'd1);
            chk("wrap drained count", 128'(count), 128'd0);
        end

        // mid-stream async reset with 3 entries and overflow set
        push_one(3'd4, 'h400, 2'd1);
        push_one(3'd4, 'h440, 2'd1);
        push_one(3'd4, 'h480, 2'd1);
        push_one(3'd4, 'h4C0, 2'd1);
        push_one(3'd4, 'h999, 2'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pre-reset count", 128'(count), 128'd3);
        chk("pre-reset overflow", 128'(overflow), 128'd1);
        chk("pre-reset head", 128'(out_addr), 128'h440);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset out_valid", 128'(out_valid), 128'd0);
        chk("async reset count", 128'(count), 128'd0);
        chk("async reset overflow", 128'(overflow), 128'd0);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post-reset out_valid", 128'(out_valid), 128'd0);
        push_one(3'd3, 'h500, 2'd1);
        chk("post-reset count", 128'(count), 128'd1);
        chk("post-reset head addr", 128'(out_addr), 128'h500);
        chk("post-reset head op", 128'(out_operation), 128'd3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post-reset drained", 128'(out_valid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
